// File: rtl/capi_sched_pkg.sv
// Shared types and widths for the CAPI command scheduler: FSM states and the
// command/response records carried between AFU engines and the PSL.
package capi_sched_pkg;

    localparam int TAG_W  = 8;
    localparam int COM_W  = 13;
    localparam int EA_W   = 64;
    localparam int SIZE_W = 12;
    localparam int CODE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [COM_W-1:0]  com;
        logic [EA_W-1:0]   ea;
        logic [SIZE_W-1:0] size;
    } command_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [CODE_W-1:0] code;
    } response_t;

endpackage

// File: rtl/capi_cmd_scheduler_arbiter.sv
// Round-robin arbiter: searches from the pointer upward, grants at most one
// requester per cycle and moves the pointer past the winner on advance.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               sum;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        sum       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = int'(ptr_q) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDX_W'(sum);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/capi_cmd_scheduler.sv
// Shares the PSL command interface among NUM_REQ engines: round-robin grant,
// tag allocation, credit tracking and routing of responses back to the issuer.
module capi_cmd_scheduler
    import capi_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_TAGS = 32,
    parameter int CREDIT_W = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic [7:0]                  croom,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*COM_W-1:0]    req_com,
    input  logic [NUM_REQ*EA_W-1:0]     req_ea,
    input  logic [NUM_REQ*SIZE_W-1:0]   req_size,
    output logic                        cmd_valid,
    output logic [TAG_W-1:0]            cmd_tag,
    output logic [COM_W-1:0]            cmd_com,
    output logic [EA_W-1:0]             cmd_ea,
    output logic [SIZE_W-1:0]           cmd_size,
    input  logic                        rsp_valid,
    input  logic [TAG_W-1:0]            rsp_tag,
    input  logic [CODE_W-1:0]           rsp_code,
    output logic [NUM_REQ-1:0]          rsp_out_valid,
    output logic [TAG_W-1:0]            rsp_out_tag,
    output logic [CODE_W-1:0]           rsp_out_code,
    output logic [CREDIT_W-1:0]         credits,
    output logic [$clog2(NUM_TAGS):0]   outstanding,
    output logic                        busy,
    output logic                        tag_err,
    output state_t                      state_dbg
);

    localparam int TIDX_W = $clog2(NUM_TAGS);
    localparam int OUT_W  = $clog2(NUM_TAGS) + 1;
    localparam int REQ_W  = $clog2(NUM_REQ);

    state_t state_q, state_nxt;

    logic [CREDIT_W-1:0] credits_q, credits_nxt;
    logic [OUT_W-1:0]    outstanding_q, outstanding_nxt;
    logic [NUM_TAGS-1:0] tag_busy_q, tag_busy_nxt;
    logic [REQ_W-1:0]    tag_owner_q [NUM_TAGS];
    logic                tag_err_q;

    logic [TIDX_W-1:0]   free_idx;
    logic                free_found;
    logic                issue_ok;
    logic                grant_fire;
    logic [NUM_REQ-1:0]  grant;
    logic [REQ_W-1:0]    grant_idx;
    logic                start_accept;

    logic                rsp_in_range;
    logic [TIDX_W-1:0]   rsp_idx;
    logic                rsp_hit;
    logic                rsp_bad;
    logic [NUM_REQ-1:0]  rsp_owner_onehot;

    command_t            sel_cmd, cmd_q;
    logic                cmd_valid_q;
    logic [TAG_W-1:0]    cmd_tag_q;
    response_t           rsp_q;
    logic [NUM_REQ-1:0]  rsp_out_valid_q;

    // Requester handshake: an engine raises req_valid and holds it with stable
    // com/ea/size until req_ready is seen high in the same cycle; that cycle
    // is the transfer, and req_ready is never high without req_valid.
    assign issue_ok     = (state_q == RUN) && !stop && (credits_q != '0) && free_found;
    assign grant_fire   = |grant;
    assign start_accept = (state_q == IDLE) && start;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (REQ_W)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (req_valid),
        .enable    (issue_ok),
        .advance   (grant_fire),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Lowest-index free tag wins; scanning downward leaves the lowest one last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (!tag_busy_q[t]) begin
                free_found = 1'b1;
                free_idx   = TIDX_W'(t);
            end
        end
    end

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_cmd.com  = req_com[i*COM_W +: COM_W];
                sel_cmd.ea   = req_ea[i*EA_W +: EA_W];
                sel_cmd.size = req_size[i*SIZE_W +: SIZE_W];
            end
        end
    end

    assign rsp_in_range = ({1'b0, rsp_tag} < 9'(NUM_TAGS));
    assign rsp_idx      = rsp_tag[TIDX_W-1:0];
    assign rsp_hit      = rsp_valid && (state_q != IDLE) && rsp_in_range && tag_busy_q[rsp_idx];
    assign rsp_bad      = rsp_valid && !rsp_hit;

    always_comb begin
        rsp_owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_owner_q[rsp_idx] == REQ_W'(i)) begin
                rsp_owner_onehot[i] = 1'b1;
            end
        end
    end

    // A grant and a returning response in the same cycle cancel out.
    always_comb begin
        credits_nxt     = credits_q;
        outstanding_nxt = outstanding_q;
        tag_busy_nxt    = tag_busy_q;
        if (grant_fire) begin
            tag_busy_nxt[free_idx] = 1'b1;
        end
        if (rsp_hit) begin
            tag_busy_nxt[rsp_idx] = 1'b0;
        end
        case ({grant_fire, rsp_hit})
            2'b10: begin
                credits_nxt     = credits_q - CREDIT_W'(1);
                outstanding_nxt = outstanding_q + OUT_W'(1);
            end
            2'b01: begin
                if (credits_q != '1) begin
                    credits_nxt = credits_q + CREDIT_W'(1);
                end
                outstanding_nxt = outstanding_q - OUT_W'(1);
            end
            default: ;
        endcase
        if (start_accept) begin
            credits_nxt = CREDIT_W'(croom);
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = (outstanding_nxt == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits_q       <= '0;
            outstanding_q   <= '0;
            tag_busy_q      <= '0;
            tag_err_q       <= 1'b0;
            cmd_valid_q     <= 1'b0;
            cmd_tag_q       <= '0;
            cmd_q           <= '0;
            rsp_q           <= '0;
            rsp_out_valid_q <= '0;
            for (int t = 0; t < NUM_TAGS; t++) begin
                tag_owner_q[t] <= '0;
            end
        end else begin
            credits_q     <= credits_nxt;
            outstanding_q <= outstanding_nxt;
            tag_busy_q    <= tag_busy_nxt;
            cmd_valid_q   <= grant_fire;
            if (grant_fire) begin
                cmd_tag_q             <= TAG_W'(free_idx);
                cmd_q                 <= sel_cmd;
                tag_owner_q[free_idx] <= grant_idx;
            end
            if (rsp_hit) begin
                rsp_out_valid_q <= rsp_owner_onehot;
                rsp_q.tag       <= rsp_tag;
                rsp_q.code      <= rsp_code;
            end else begin
                rsp_out_valid_q <= '0;
            end
            if (rsp_bad) begin
                tag_err_q <= 1'b1;
            end else if (start_accept) begin
                tag_err_q <= 1'b0;
            end
        end
    end

    assign req_ready     = grant;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_tag       = cmd_tag_q;
    assign cmd_com       = cmd_q.com;
    assign cmd_ea        = cmd_q.ea;
    assign cmd_size      = cmd_q.size;
    assign rsp_out_valid = rsp_out_valid_q;
    assign rsp_out_tag   = rsp_q.tag;
    assign rsp_out_code  = rsp_q.code;
    assign credits       = credits_q;
    assign outstanding   = outstanding_q;
    assign busy          = (state_q != IDLE);
    assign tag_err       = tag_err_q;
    assign state_dbg     = state_q;

endmodule
